// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmit line among NUM_REQ byte sources.
// A granted byte is latched, acknowledged with a one-cycle pulse and shifted out LSB first.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned OWNER_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   data_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [OWNER_W-1:0]     owner,
  output logic                   txd
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [OWNER_W-1:0]   last_grant, last_grant_nxt;
  logic [OWNER_W-1:0]   owner_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 busy_nxt;
  logic                 txd_nxt;

  logic                 grant_valid;
  logic [OWNER_W-1:0]   grant_idx;
  logic [OWNER_W-1:0]   cand;

  // First pending requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = OWNER_W'((32'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      last_grant <= OWNER_W'(NUM_REQ - 1);
      owner      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      txd        <= 1'b1;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      txd        <= txd_nxt;
    end
  end

  // Next-state logic; every serial phase lasts CLKS_PER_BIT cycles via bit_cnt.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    ack_nxt        = '0;
    busy_nxt       = busy;
    txd_nxt        = txd;

    case (state)
      IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (grant_valid) begin
          state_nxt      = START;
          shift_nxt      = data_in[{grant_idx, 3'b000} +: 8];
          owner_nxt      = grant_idx;
          last_grant_nxt = grant_idx;
          ack_nxt        = NUM_REQ'(1) << grant_idx;
          busy_nxt       = 1'b1;
          txd_nxt        = 1'b0;
          bit_cnt_nxt    = '0;
          bit_idx_nxt    = '0;
        end
      end
      START: begin
        if (bit_cnt == CNT_MAX) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
          txd_nxt     = shift[0];
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt == CNT_MAX) begin
          bit_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            txd_nxt     = shift[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_cnt == CNT_MAX) begin
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          txd_nxt     = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a negedge monitor decodes frames and acks,
// scenario tasks push expected frames and compare them against the decoded ones.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int C = 16;
  localparam int FRAME = 10 * C;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data_in;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     owner;
  logic           txd;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .ack(ack), .busy(busy), .owner(owner), .txd(txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int owner; logic [7:0] data; int start; int len; logic start_ok; logic stop_ok; } frame_t;
  typedef struct { int owner; logic [7:0] data; } exp_t;
  typedef struct { int cyc; logic [N-1:0] val; } ack_t;

  frame_t obs_q[$];
  exp_t   exp_q[$];
  ack_t   ack_q[$];
  int     abort_cnt = 0;
  int     checks = 0;
  int     failures = 0;

  // Frame decoder: samples each bit mid-period from the first busy cycle.
  bit     mon_active = 0;
  int     mon_pos;
  frame_t mon_fr;
  always @(negedge clk) begin
    if (ack !== '0) ack_q.push_back('{cyc, ack});
    if (mon_active) begin
      mon_pos++;
      if (busy !== 1'b1) begin
        mon_active = 0;
        mon_fr.len = mon_pos;
        if (mon_pos == FRAME) obs_q.push_back(mon_fr);
        else abort_cnt++;
      end else if (mon_pos == C/2) begin
        mon_fr.start_ok = (txd === 1'b0);
      end else if (mon_pos == C/2 + 9*C) begin
        mon_fr.stop_ok = (txd === 1'b1);
      end else if (mon_pos > C/2 && (mon_pos - C/2) % C == 0) begin
        mon_fr.data[(mon_pos - C/2)/C - 1] = txd;
      end
    end else if (busy === 1'b1 && txd === 1'b0) begin
      mon_active      = 1;
      mon_pos         = 0;
      mon_fr.owner    = int'(owner);
      mon_fr.start    = cyc;
      mon_fr.data     = 8'h00;
      mon_fr.len      = 0;
      mon_fr.start_ok = 1'b0;
      mon_fr.stop_ok  = 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    ack_q.delete();
    abort_cnt = 0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    while (ack_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (ack_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b want=1", txd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b want=0000", ack); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d want=0", owner); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    do_reset();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || ack !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_stable bad_cycles=%0d want=0", bad); end
    checks++; if (ack_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL idle_no_activity acks=%0d frames=%0d want=0/0", ack_q.size(), obs_q.size());
    end
  endtask

  task automatic test_single();
    logic [9:0] want_bits;
    bit ok;
    exp_t e;
    frame_t f;
    do_reset();
    want_bits = 10'b1_1010_0101_0;
    data_in[7:0] = 8'hA5;
    req = 4'b0001;
    exp_q.push_back('{0, 8'hA5});
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack_c1 got=%b want=0001", ack); end
    checks++; if (busy !== 1'b1 || owner !== 2'd0) begin
      failures++; $display("FAIL single_busy_owner got=%b/%0d want=1/0", busy, owner);
    end
    req = '0;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_ack_c2 got=%b want=0000", ack); end
    repeat (C/2 - 1) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      if (b != 0) repeat (C) @(negedge clk);
      checks++; if (txd !== want_bits[b]) begin
        failures++; $display("FAIL single_txd_bit%0d got=%b want=%b", b, txd, want_bits[b]);
      end
    end
    wait_obs(1, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_frame_timeout frames=%0d want=1", obs_q.size()); end
    else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (f.owner != e.owner || f.data !== e.data || f.len != FRAME) begin
        failures++; $display("FAIL single_frame got=%0d/%h/%0d want=%0d/%h/%0d", f.owner, f.data, f.len, e.owner, e.data, FRAME);
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    int prev;
    exp_t e;
    frame_t f;
    do_reset();
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    foreach (exp_q[i]) ;
    exp_q.push_back('{0, 8'h11});
    exp_q.push_back('{1, 8'h22});
    exp_q.push_back('{2, 8'h33});
    exp_q.push_back('{3, 8'h44});
    exp_q.push_back('{0, 8'h11});
    req = 4'b1111;
    wait_acks(5, 1200, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL contention_ack_timeout acks=%0d want=5", ack_q.size()); end
    wait_obs(5, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL contention_frame_timeout frames=%0d want=5", obs_q.size()); end
    prev = -1;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (f.owner != e.owner || f.data !== e.data || f.len != FRAME || !f.start_ok || !f.stop_ok) begin
        failures++; $display("FAIL contention_frame got=%0d/%h/%0d want=%0d/%h/%0d", f.owner, f.data, f.len, e.owner, e.data, FRAME);
      end
      if (prev >= 0) begin
        checks++; if (f.start - prev != FRAME + 1) begin
          failures++; $display("FAIL contention_spacing got=%0d want=%0d", f.start - prev, FRAME + 1);
        end
      end
      prev = f.start;
    end
  endtask

  task automatic test_rotation();
    bit ok;
    logic [N-1:0] want_ack[4];
    exp_t e;
    frame_t f;
    do_reset();
    want_ack = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    data_in = {8'h99, 8'h00, 8'h66, 8'h00};
    exp_q.push_back('{1, 8'h66});
    exp_q.push_back('{3, 8'h99});
    exp_q.push_back('{1, 8'h66});
    exp_q.push_back('{3, 8'h99});
    req = 4'b1010;
    wait_acks(4, 1000, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL rotation_ack_timeout acks=%0d want=4", ack_q.size()); end
    wait_obs(4, 400, ok);
    checks++; if (!ok || ack_q.size() != 4) begin
      failures++; $display("FAIL rotation_counts frames=%0d acks=%0d want=4/4", obs_q.size(), ack_q.size());
    end
    for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
      checks++; if (ack_q[i].val !== want_ack[i]) begin
        failures++; $display("FAIL rotation_ack%0d got=%b want=%b", i, ack_q[i].val, want_ack[i]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (f.owner != e.owner || f.data !== e.data) begin
        failures++; $display("FAIL rotation_frame got=%0d/%h want=%0d/%h", f.owner, f.data, e.owner, e.data);
      end
    end
  endtask

  task automatic test_late_arrival();
    bit ok;
    exp_t e;
    frame_t f;
    do_reset();
    data_in[7:0] = 8'h3C;
    req = 4'b0001;
    exp_q.push_back('{0, 8'h3C});
    exp_q.push_back('{2, 8'h5A});
    wait_acks(1, 20, ok);
    req = '0;
    repeat (50) @(negedge clk);
    data_in[23:16] = 8'h5A;
    req[2] = 1'b1;
    wait_acks(2, 400, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL late_ack_timeout acks=%0d want=2", ack_q.size()); end
    else begin
      checks++; if (ack_q[1].val !== 4'b0100 || ack_q[1].cyc - ack_q[0].cyc != FRAME + 1) begin
        failures++; $display("FAIL late_ack got=%b@+%0d want=0100@+%0d", ack_q[1].val, ack_q[1].cyc - ack_q[0].cyc, FRAME + 1);
      end
    end
    wait_obs(2, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL late_frame_timeout frames=%0d want=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (f.owner != e.owner || f.data !== e.data || f.len != FRAME) begin
        failures++; $display("FAIL late_frame got=%0d/%h/%0d want=%0d/%h/%0d", f.owner, f.data, f.len, e.owner, e.data, FRAME);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s;
    int guard;
    frame_t f;
    do_reset();
    data_in = {8'h00, 8'h00, 8'h77, 8'hC3};
    req = 4'b0011;
    wait_acks(1, 20, ok);
    checks++; if (!ok || ack_q[0].val !== 4'b0001) begin failures++; $display("FAIL rstmid_first_grant acks=%0d want=0001", ack_q.size()); end
    s = ok ? ack_q[0].cyc : cyc;
    // Land inside data bit 3, which spans offsets 4*C..5*C-1 from the start bit.
    guard = 0;
    while (cyc < s + 4*C + C/2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (txd !== 1'b1 || busy !== 1'b0 || ack !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%b want=1/0/0000", txd, busy, ack);
    end
    @(negedge clk);
    checks++; if (ack !== 4'b0001 || owner !== 2'd0) begin
      failures++; $display("FAIL rstmid_regrant got=%b/%0d want=0001/0", ack, owner);
    end
    req = '0;
    wait_obs(1, 400, ok);
    checks++; if (!ok || abort_cnt != 1) begin
      failures++; $display("FAIL rstmid_counts frames=%0d aborts=%0d want=1/1", obs_q.size(), abort_cnt);
    end
    if (ok) begin
      f = obs_q.pop_front();
      checks++; if (f.owner != 0 || f.data !== 8'hC3 || f.len != FRAME) begin
        failures++; $display("FAIL rstmid_frame got=%0d/%h/%0d want=0/c3/%0d", f.owner, f.data, f.len, FRAME);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_contention();
    test_rotation();
    test_late_arrival();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
